// File: rtl/sprite_rom_arbiter_if.sv
// Request/grant, ROM and read-return signals shared by the sprite ROM arbiter and its clients.
interface sprite_rom_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        gnt;
   logic                      rom_rd;
   logic [ADDR_W-1:0]         rom_addr;
   logic [DATA_W-1:0]         rom_q;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;
   logic                      busy;

   modport master (
      output req, req_addr, rom_q,
      input  gnt, rom_rd, rom_addr, rvalid, rdata, busy
   );

   modport slave (
      input  req, req_addr, rom_q,
      output gnt, rom_rd, rom_addr, rvalid, rdata, busy
   );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port pattern ROM among NUM_REQ requesters: one read per clock,
// optional strict priority for requester 0, round-robin for the rest, tagged in-order returns.
module sprite_rom_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ROM_LAT = 2,
   parameter int unsigned PRIO0   = 1
) (
   input logic                 Clk,
   input logic                 Reset_n,
   sprite_rom_arbiter_if.slave bus
);
   localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned RR_BASE = (PRIO0 != 0) ? 1 : 0;
   localparam int unsigned RR_SIZE = NUM_REQ - RR_BASE;
   localparam logic [PTR_W-1:0] BASE_IDX = PTR_W'(RR_BASE);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_c;
   logic [PTR_W-1:0]   win_idx;
   logic               win_any;
   logic               rom_rd_q, rom_rd_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic               busy_q, busy_d;
   logic [NUM_REQ-1:0] tag_q [ROM_LAT+1];
   logic [NUM_REQ-1:0] tag_d [ROM_LAT+1];

   // Grant selection and round-robin pointer advance; nothing is granted while in reset.
   always_comb begin
      logic [PTR_W-1:0] idx;
      gnt_c   = '0;
      ptr_d   = ptr_q;
      win_idx = '0;
      win_any = 1'b0;
      idx     = ptr_q;
      if (Reset_n) begin
         if ((PRIO0 != 0) && bus.req[0]) begin
            gnt_c[0] = 1'b1;
            win_any  = 1'b1;
         end else begin
            for (int unsigned k = 0; k < RR_SIZE; k++) begin
               if (!win_any && bus.req[idx]) begin
                  win_any      = 1'b1;
                  win_idx      = idx;
                  gnt_c[idx]   = 1'b1;
                  ptr_d        = (idx == LAST_IDX) ? BASE_IDX : PTR_W'(idx + PTR_W'(1));
               end
               idx = (idx == LAST_IDX) ? BASE_IDX : PTR_W'(idx + PTR_W'(1));
            end
         end
      end
   end

   // Issue stage and one-hot tag pipeline; stage ROM_LAT lines up with rom_q.
   always_comb begin
      rom_rd_d   = win_any;
      rom_addr_d = win_any ? bus.req_addr[win_idx*ADDR_W +: ADDR_W] : rom_addr_q;
      tag_d[0]   = gnt_c;
      busy_d     = win_any;
      for (int unsigned k = 1; k <= ROM_LAT; k++) begin
         tag_d[k] = tag_q[k-1];
         busy_d   = busy_d | (|tag_q[k-1]);
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         ptr_q      <= PTR_W'(RR_BASE);
         rom_rd_q   <= 1'b0;
         rom_addr_q <= '0;
         busy_q     <= 1'b0;
         for (int unsigned k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rom_rd_q   <= rom_rd_d;
         rom_addr_q <= rom_addr_d;
         busy_q     <= busy_d;
         for (int unsigned k = 0; k <= ROM_LAT; k++) tag_q[k] <= tag_d[k];
      end
   end

   assign bus.gnt      = gnt_c;
   assign bus.rom_rd   = rom_rd_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.rvalid   = tag_q[ROM_LAT];
   assign bus.rdata    = DATA_W'(bus.rom_q);
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench: a 4-requester priority instance and a 2-requester pure round-robin instance.
module tb_sprite_rom_arbiter;
   logic Clk;
   logic Reset_n;
   int   checks = 0;
   int   errors = 0;

   localparam logic [10:0] A0 = 11'h010, A1 = 11'h111, A2 = 11'h123, A3 = 11'h333;
   localparam logic [10:0] B0 = 11'h0AA, B1 = 11'h155;

   logic [3:0]  rr_exp  [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
   logic [10:0] rr_addr [6] = '{A1, A2, A3, A1, A2, A3};
   logic [1:0]  q_exp   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [10:0] q_addr  [4] = '{B0, B1, B0, B1};

   sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(8)) ia ();
   sprite_rom_arbiter_if #(.NUM_REQ(2), .ADDR_W(11), .DATA_W(8)) ib ();

   sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(8), .ROM_LAT(2), .PRIO0(1)) dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .bus(ia.slave)
   );
   sprite_rom_arbiter #(.NUM_REQ(2), .ADDR_W(11), .DATA_W(8), .ROM_LAT(2), .PRIO0(0)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .bus(ib.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset_n     = 1'b0;
      ia.req      = 4'b1111;
      ia.req_addr = {A3, A2, A1, A0};
      ia.rom_q    = 8'h00;
      ib.req      = 2'b00;
      ib.req_addr = {B1, B0};
      ib.rom_q    = 8'h00;

      // reset hold with all requests high
      for (int k = 0; k < 3; k++) begin
         next_cycle(); #1;
         chk("rst_gnt",    32'(ia.gnt),    32'h0);
         chk("rst_rom_rd", 32'(ia.rom_rd), 32'h0);
         chk("rst_rvalid", 32'(ia.rvalid), 32'h0);
         chk("rst_busy",   32'(ia.busy),   32'h0);
      end
      next_cycle(); Reset_n = 1'b1; #1;
      chk("rel_gnt", 32'(ia.gnt), 32'h1);
      next_cycle(); ia.req = 4'b0000; #1;
      chk("rel_rom_rd",   32'(ia.rom_rd),   32'h1);
      chk("rel_rom_addr", 32'(ia.rom_addr), 32'(A0));
      chk("rel_busy",     32'(ia.busy),     32'h1);
      next_cycle(); #1;
      chk("rel_rvalid_early", 32'(ia.rvalid), 32'h0);
      next_cycle(); ia.rom_q = 8'h3C; #1;
      chk("rel_rvalid", 32'(ia.rvalid), 32'h1);
      chk("rel_rdata",  32'(ia.rdata),  32'h3C);
      next_cycle(); #1;
      chk("idle_busy",   32'(ia.busy),   32'h0);
      chk("idle_rvalid", 32'(ia.rvalid), 32'h0);

      // single read, latency 1 + ROM_LAT
      next_cycle(); ia.req = 4'b0100; #1;
      chk("single_gnt", 32'(ia.gnt), 32'h4);
      next_cycle(); ia.req = 4'b0000; #1;
      chk("single_rom_rd",   32'(ia.rom_rd),   32'h1);
      chk("single_rom_addr", 32'(ia.rom_addr), 32'h123);
      chk("single_gnt_off",  32'(ia.gnt),      32'h0);
      next_cycle(); #1;
      chk("single_rvalid_early", 32'(ia.rvalid), 32'h0);
      next_cycle(); ia.rom_q = 8'hA5; #1;
      chk("single_rvalid", 32'(ia.rvalid), 32'h4);
      chk("single_rdata",  32'(ia.rdata),  32'hA5);

      // pointer back to 1, then round-robin wrap with back-to-back returns
      next_cycle(); Reset_n = 1'b0; #1;
      for (int k = 0; k < 9; k++) begin
         next_cycle();
         if (k == 0) Reset_n = 1'b1;
         ia.req   = (k < 6) ? 4'b1110 : 4'b0000;
         ia.rom_q = 8'(32'h40 + k);
         #1;
         chk("rr_gnt", 32'(ia.gnt), (k < 6) ? 32'(rr_exp[k]) : 32'h0);
         if (k == 0) chk("rr_busy_after_rst", 32'(ia.busy), 32'h0);
         if (k >= 1 && k <= 6) begin
            chk("rr_rom_rd",   32'(ia.rom_rd),   32'h1);
            chk("rr_rom_addr", 32'(ia.rom_addr), 32'(rr_addr[k-1]));
         end
         if (k >= 3) begin
            chk("rr_rvalid", 32'(ia.rvalid), 32'(rr_exp[k-3]));
            chk("rr_rdata",  32'(ia.rdata),  32'h40 + 32'(k));
         end else begin
            chk("rr_rvalid_none", 32'(ia.rvalid), 32'h0);
         end
      end

      // requester 0 preempts for one cycle; round-robin resumes at saved pointer
      next_cycle(); ia.req = 4'b0110; #1;
      chk("pre_gnt0", 32'(ia.gnt), 32'h2);
      next_cycle(); #1;
      chk("pre_gnt1", 32'(ia.gnt), 32'h4);
      next_cycle(); ia.req = 4'b0111; #1;
      chk("pre_gnt2", 32'(ia.gnt), 32'h1);
      next_cycle(); ia.req = 4'b0110; #1;
      chk("pre_gnt3",     32'(ia.gnt),      32'h2);
      chk("pre_rom_addr", 32'(ia.rom_addr), 32'(A0));
      next_cycle(); ia.req = 4'b0000; #1;
      chk("pre_gnt4",      32'(ia.gnt),      32'h0);
      chk("pre_rom_addr1", 32'(ia.rom_addr), 32'(A1));
      next_cycle(); #1;
      chk("pre_rvalid0", 32'(ia.rvalid), 32'h1);
      next_cycle(); #1;
      chk("pre_rvalid1", 32'(ia.rvalid), 32'h2);

      // reset while reads are in flight
      next_cycle(); ia.req = 4'b1000; #1;
      chk("mid_gnt0", 32'(ia.gnt), 32'h8);
      next_cycle(); ia.req = 4'b0010; #1;
      chk("mid_gnt1", 32'(ia.gnt), 32'h2);
      next_cycle(); ia.req = 4'b1111; Reset_n = 1'b0; #1;
      chk("mid_gnt_forced", 32'(ia.gnt), 32'h0);
      next_cycle(); ia.req = 4'b0000; Reset_n = 1'b1; #1;
      chk("mid_rvalid3",  32'(ia.rvalid),   32'h0);
      chk("mid_busy",     32'(ia.busy),     32'h0);
      chk("mid_rom_rd",   32'(ia.rom_rd),   32'h0);
      chk("mid_rom_addr", 32'(ia.rom_addr), 32'h0);
      next_cycle(); #1;
      chk("mid_rvalid4", 32'(ia.rvalid), 32'h0);
      next_cycle(); #1;
      chk("mid_rvalid5", 32'(ia.rvalid), 32'h0);

      // two requesters, no priority: strict alternation
      for (int k = 0; k < 7; k++) begin
         next_cycle();
         ib.req   = (k < 4) ? 2'b11 : 2'b00;
         ib.rom_q = 8'(32'h80 + k);
         #1;
         chk("b_gnt", 32'(ib.gnt), (k < 4) ? 32'(q_exp[k]) : 32'h0);
         if (k >= 1 && k <= 4) chk("b_rom_addr", 32'(ib.rom_addr), 32'(q_addr[k-1]));
         if (k >= 3) begin
            chk("b_rvalid", 32'(ib.rvalid), 32'(q_exp[k-3]));
            chk("b_rdata",  32'(ib.rdata),  32'h80 + 32'(k));
         end else begin
            chk("b_rvalid_none", 32'(ib.rvalid), 32'h0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
